intr_prio_arbiter: RTL and testbench
====================================

Name: intr_prio_arbiter

Overview:
- Parametrised, sequential successor to the three-bus (A/B/C × 9-channel) priority interrupt encoder.
- Takes N_GRP groups of N_CH request lines, each with its own enable.
- Latches requests into a pending register and arbitrates by fixed priority.
- Presents one winner at a time (group flag + channel index) through a valid/ack handshake. Sits between peripheral request lines and the interrupt-servicing controller.

Parameters:
- N_GRP, 3, number of priority groups; group 0 has highest priority.
- N_CH, 9, channels per group; channel 0 has highest priority within a group.
- CH_W, 4, width of chan_out; must be >= ceil(log2(N_CH)).
- MODE, 1, request capture mode: 0 = level, 1 = rising-edge latched.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_in  input  N_GRP*N_CH  per-line enable; line index = g*N_CH + c.
- req_in  input  N_GRP*N_CH  per-line request; same indexing.
- irq_ack  input  1  acknowledges the presented interrupt.
- ovr_clr  input  1  clears ovr_out.
- irq_valid  output  1  a winner is being presented.
- grp_out  output  N_GRP  one-hot group of the presented line; 0 when not valid.
- chan_out  output  CH_W  channel index within the group; 0 when not valid.
- ovr_out  output  1  sticky overrun flag.

Behaviour:
- Reset (async, rst=1): all registers cleared immediately, independent of clk. irq_valid=0, grp_out=0, chan_out=0, ovr_out=0; pending and input registers cleared; FSM in IDLE. Takes effect mid-presentation too.
- Stage 1: en_in and req_in registered every cycle (en_r, req_r).
- Stage 2, pending register pend:
  - MODE=1: a bit sets on req_r rising edge (req_r=1, previous req_r=0) while en_r=1. It clears on ack of that line. If set and clear coincide on the same bit, set wins.
  - MODE=0: pend <= req_r & en_r each cycle; ack does not clear it.
- Overrun (MODE=1 only): a qualifying rising edge on a line whose pend bit is already 1 sets ovr_out. ovr_clr clears ovr_out. Set wins over a simultaneous clear.
- Arbitration: eligible = pend & en_r. The winner is the lowest group with any eligible bit, and the lowest channel within that group.
- FSM:
  - IDLE: if eligible != 0, capture the winner into output registers, irq_valid <= 1, go to PRESENT.
  - PRESENT: outputs frozen. No preemption by a higher-priority arrival. No revocation if the line's enable drops. On irq_ack=1: clear that pend bit (MODE=1), irq_valid <= 0, grp_out/chan_out <= 0, go to IDLE.
  - irq_ack in IDLE is ignored.
- Timing:
  - Request sampled at edge k → pend at edge k+1 → irq_valid high after edge k+2.
  - After an ack edge there is a minimum of one cycle with irq_valid low before the next presentation.
- MODE=0: a line still asserted after ack is re-presented after the one-cycle gap.
- Width: chan_out is zero-extended to CH_W. Unused index values never appear.

Test Plan (defaults N_GRP=3, N_CH=9, CH_W=4, MODE=1 unless stated):
1. Reset: assert rst mid-cycle with requests pending and irq_valid=1 → irq_valid, grp_out, chan_out, ovr_out go to 0 without a clock edge. After release with no requests, they stay 0.
2. Single request: en_in all 1s, pulse req_in[14] one cycle sampled at edge k → irq_valid=1, grp_out=3'b010, chan_out=4'd5 after edge k+2. Hold ack low 5 cycles → stable. Ack at edge m → irq_valid=0 after m, never re-presented.
3. Priority order: raise req bits 20, 10, 3 on the same cycle → presentations in order (grp 3'b001, chan 3), (3'b010, chan 1), (3'b100, chan 2). Each is separated by ≥1 invalid cycle. Bit 0 raised during the first presentation does not preempt and is presented second.
4. Masking: en_in[3]=0, pulse req bits 3 and 7 → only (3'b001, chan 7) presented. Setting en_in[3]=1 later does not present 3.
5. Overrun: two separate rising edges on req_in[0] before ack → ovr_out=1 and a single presentation of chan 0. Pulse ovr_clr → ovr_out=0.
6. MODE=0: hold req_in[26]=1, ack each presentation → (3'b100, chan 8) re-presented after each 1-cycle gap. Drop req_in[26] → no further presentation once the drop propagates (2 cycles).

Source files
------------

// File: rtl/intr_prio_arbiter.sv
// Fixed-priority interrupt arbiter: N_GRP x N_CH request lines latched into pend, one winner presented at a time.
// Latency: request sampled at edge k is presented after edge k+2; irq_valid holds until irq_ack, then drops for at least one cycle.
module intr_prio_arbiter #(
    parameter int N_GRP = 3,
    parameter int N_CH  = 9,
    parameter int CH_W  = 4,
    parameter int MODE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_GRP*N_CH-1:0]  en_in,
    input  logic [N_GRP*N_CH-1:0]  req_in,
    input  logic                   irq_ack,
    input  logic                   ovr_clr,
    output logic                   irq_valid,
    output logic [N_GRP-1:0]       grp_out,
    output logic [CH_W-1:0]        chan_out,
    output logic                   ovr_out
);

    localparam int N     = N_GRP * N_CH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t            state, state_nxt;
    logic [N-1:0]      en_r, req_r, req_d;
    logic [N-1:0]      pend, pend_nxt, elig, rise, clr_mask;
    logic              ovr, ovr_nxt;
    logic [N_GRP-1:0]  grp_q, grp_nxt, grp_win;
    logic [CH_W-1:0]   chan_q, chan_nxt, chan_win;
    logic [IDX_W-1:0]  idx_q, idx_nxt, idx_win;
    logic              found;

    assign elig = pend & en_r;
    assign rise = req_r & ~req_d & en_r;

    // Scan from lowest priority upward so the last hit is the lowest group, lowest channel.
    always_comb begin
        found    = 1'b0;
        grp_win  = '0;
        chan_win = '0;
        idx_win  = '0;
        for (int g = N_GRP - 1; g >= 0; g--) begin
            for (int c = N_CH - 1; c >= 0; c--) begin
                if (elig[g*N_CH + c]) begin
                    found    = 1'b1;
                    grp_win  = '0;
                    grp_win[g] = 1'b1;
                    chan_win = CH_W'(c);
                    idx_win  = IDX_W'(g*N_CH + c);
                end
            end
        end
    end

    // Edge mode: a new edge beats an ack on the same line; an edge on an already pending line is an overrun.
    always_comb begin
        clr_mask = '0;
        pend_nxt = pend;
        ovr_nxt  = ovr;
        if (MODE == 1) begin
            if (state == PRESENT && irq_ack)
                clr_mask[idx_q] = 1'b1;
            pend_nxt = (pend & ~clr_mask) | rise;
            ovr_nxt  = (|(rise & pend)) | (ovr & ~ovr_clr);
        end else begin
            pend_nxt = req_r & en_r;
            ovr_nxt  = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        grp_nxt   = grp_q;
        chan_nxt  = chan_q;
        idx_nxt   = idx_q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = PRESENT;
                    grp_nxt   = grp_win;
                    chan_nxt  = chan_win;
                    idx_nxt   = idx_win;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    state_nxt = IDLE;
                    grp_nxt   = '0;
                    chan_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r   <= '0;
            req_r  <= '0;
            req_d  <= '0;
            pend   <= '0;
            ovr    <= 1'b0;
            state  <= IDLE;
            grp_q  <= '0;
            chan_q <= '0;
            idx_q  <= '0;
        end else begin
            en_r   <= en_in;
            req_r  <= req_in;
            req_d  <= req_r;
            pend   <= pend_nxt;
            ovr    <= ovr_nxt;
            state  <= state_nxt;
            grp_q  <= grp_nxt;
            chan_q <= chan_nxt;
            idx_q  <= idx_nxt;
        end
    end

    assign irq_valid = (state == PRESENT);
    assign grp_out   = grp_q;
    assign chan_out  = chan_q;
    assign ovr_out   = ovr;

endmodule

// File: tb/tb_intr_prio_arbiter.sv
// Directed bench for intr_prio_arbiter: edge-mode instance (dut1) and level-mode instance (dut0).
module tb_intr_prio_arbiter;

    localparam int N = 27;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0] en1, req1, en0, req0;
    logic         ack1, ack0, oc1, oc0;
    logic         v1, v0, o1, o0;
    logic [2:0]   g1, g0;
    logic [3:0]   c1, c0;

    wire [7:0] p1 = {v1, g1, c1};
    wire [7:0] p0 = {v0, g0, c0};

    int n_chk  = 0;
    int n_pass = 0;

    intr_prio_arbiter #(.N_GRP(3), .N_CH(9), .CH_W(4), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en_in(en1), .req_in(req1), .irq_ack(ack1), .ovr_clr(oc1),
        .irq_valid(v1), .grp_out(g1), .chan_out(c1), .ovr_out(o1)
    );

    intr_prio_arbiter #(.N_GRP(3), .N_CH(9), .CH_W(4), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en_in(en0), .req_in(req0), .irq_ack(ack0), .ovr_clr(oc0),
        .irq_valid(v0), .grp_out(g0), .chan_out(c0), .ovr_out(o0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_next(input string tag, input logic [7:0] exp);
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        check({tag, "_gap"}, p1, 8'h00);
        step();
        check(tag, p1, exp);
    endtask

    initial begin
        rst  = 1'b1;
        en1  = '1; req1 = '0; ack1 = 1'b0; oc1 = 1'b0;
        en0  = '1; req0 = '0; ack0 = 1'b0; oc0 = 1'b0;
        #12;
        check("rst_pres1", p1, 8'h00);
        check("rst_ovr1", o1, 0);
        check("rst_pres0", p0, 8'h00);
        rst = 1'b0;
        step();

        // single request on line 14 = group 1, channel 5
        req1[14] = 1'b1;
        step();
        req1[14] = 1'b0;
        check("t2_k", p1, 8'h00);
        step();
        check("t2_k1", p1, 8'h00);
        step();
        check("t2_k2", p1, {1'b1, 3'b010, 4'd5});
        repeat (5) begin
            step();
            check("t2_hold", p1, {1'b1, 3'b010, 4'd5});
        end
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        check("t2_ack", p1, 8'h00);
        repeat (4) begin
            step();
            check("t2_idle", p1, 8'h00);
        end

        // priority order, late high-priority arrival does not preempt
        req1[20] = 1'b1; req1[10] = 1'b1; req1[3] = 1'b1;
        step();
        req1 = '0;
        step();
        step();
        check("t3_p1", p1, {1'b1, 3'b001, 4'd3});
        req1[0] = 1'b1;
        step();
        req1[0] = 1'b0;
        step();
        step();
        check("t3_nopre", p1, {1'b1, 3'b001, 4'd3});
        ack_next("t3_p2", {1'b1, 3'b001, 4'd0});
        ack_next("t3_p3", {1'b1, 3'b010, 4'd1});
        ack_next("t3_p4", {1'b1, 3'b100, 4'd2});
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        step();
        check("t3_done", p1, 8'h00);

        // masking: disabled line never pends, re-enabling does not resurrect it
        en1[3] = 1'b0;
        req1[3] = 1'b1; req1[7] = 1'b1;
        step();
        req1 = '0;
        step();
        step();
        check("t4_p", p1, {1'b1, 3'b001, 4'd7});
        en1 = '1;
        step();
        step();
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        check("t4_gap", p1, 8'h00);
        step();
        step();
        check("t4_none", p1, 8'h00);
        check("t4_ovr", o1, 0);

        // overrun: second edge on line 0 before ack
        req1[0] = 1'b1;
        step();
        req1 = '0;
        step();
        step();
        check("t5_p", p1, {1'b1, 3'b001, 4'd0});
        check("t5_ovr0", o1, 0);
        req1[0] = 1'b1;
        step();
        req1 = '0;
        step();
        check("t5_ovr1", o1, 1);
        check("t5_still", p1, {1'b1, 3'b001, 4'd0});
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        step();
        step();
        check("t5_single", p1, 8'h00);
        oc1 = 1'b1;
        step();
        oc1 = 1'b0;
        check("t5_clr", o1, 0);

        // async reset mid-presentation with overrun set
        req1[2] = 1'b1;
        step();
        req1[2] = 1'b0;
        step();
        req1[2] = 1'b1;
        step();
        req1[2] = 1'b0;
        step();
        check("t1_pre", {o1, p1}, {1'b1, 1'b1, 3'b001, 4'd2});
        #2;
        rst = 1'b1;
        #1;
        check("t1_async", {o1, p1}, 9'h000);
        #2;
        rst = 1'b0;
        repeat (3) step();
        check("t1_post", {o1, p1}, 9'h000);

        // level mode: held line re-presented after each one-cycle gap
        req0[26] = 1'b1;
        step();
        step();
        step();
        check("t6_p", p0, {1'b1, 3'b100, 4'd8});
        repeat (3) begin
            ack0 = 1'b1;
            step();
            ack0 = 1'b0;
            check("t6_gap", p0, 8'h00);
            step();
            check("t6_rep", p0, {1'b1, 3'b100, 4'd8});
        end
        req0[26] = 1'b0;
        step();
        step();
        check("t6_norevoke", p0, {1'b1, 3'b100, 4'd8});
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        step();
        step();
        check("t6_gone", p0, 8'h00);
        step();
        check("t6_gone2", p0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
